// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping fetch (T0-T2) and opcode-driven execute (T3-T7).
// Optional macro SEQ_MEM_WAIT_EN adds a mem_ready input that stretches the memory cycles.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        con_ff,
`ifdef SEQ_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        pc_in,
    output logic        read,
    output logic        write,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlo_out,
    output logic        c_out,
    output logic        con_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic [4:0]  alu_op,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_PAUSE = 4'd9,
        S_HALT  = 4'd10
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_RLO  = 5'b00011;
    localparam logic [4:0] OP_RHI  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    state_t     state_r;
    state_t     next_state_s;
    state_t     boundary_next_s;
    logic [4:0] opcode_s;
    logic       is_ld_s;
    logic       is_ldi_s;
    logic       is_st_s;
    logic       is_r_s;
    logic       is_imm_s;
    logic       is_br_s;
    logic       is_halt_s;
    logic       mem_ready_s;
    logic       unused_ir_s;

    // Immediate-class ALU code; ld, st, ldi and addi all need an add.
    function automatic logic [4:0] imm_alu_code(input logic [4:0] op);
        case (op)
            OP_ANDI: imm_alu_code = ALU_AND;
            OP_ORI:  imm_alu_code = ALU_OR;
            default: imm_alu_code = ALU_ADD;
        endcase
    endfunction

    assign opcode_s    = ir[31:27];
    assign unused_ir_s = ^ir[26:0];
    assign is_ld_s     = (opcode_s == OP_LD);
    assign is_ldi_s    = (opcode_s == OP_LDI);
    assign is_st_s     = (opcode_s == OP_ST);
    assign is_r_s      = (opcode_s >= OP_RLO) && (opcode_s <= OP_RHI);
    assign is_imm_s    = (opcode_s >= OP_ADDI) && (opcode_s <= OP_ORI);
    assign is_br_s     = (opcode_s == OP_BR);
    assign is_halt_s   = (opcode_s == OP_HALT);

`ifdef SEQ_MEM_WAIT_EN
    assign mem_ready_s = mem_ready;
`else
    assign mem_ready_s = 1'b1;
`endif

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_RST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; stop is honoured only at an instruction boundary.
    always_comb begin
        boundary_next_s = stop ? S_PAUSE : S_T0;
        next_state_s    = S_RST;
        case (state_r)
            S_RST:   next_state_s = S_T0;
            S_T0:    next_state_s = S_T1;
            S_T1:    next_state_s = mem_ready_s ? S_T2 : S_T1;
            S_T2:    next_state_s = is_halt_s ? S_HALT : S_T3;
            S_T3: begin
                if (is_ld_s || is_st_s || is_ldi_s || is_r_s || is_imm_s || is_br_s) begin
                    next_state_s = S_T4;
                end else begin
                    next_state_s = boundary_next_s;
                end
            end
            S_T4:    next_state_s = S_T5;
            S_T5: begin
                if (is_ld_s || is_st_s || is_br_s) begin
                    next_state_s = S_T6;
                end else begin
                    next_state_s = boundary_next_s;
                end
            end
            S_T6: begin
                if (is_ld_s) begin
                    next_state_s = mem_ready_s ? S_T7 : S_T6;
                end else if (is_st_s) begin
                    next_state_s = S_T7;
                end else begin
                    next_state_s = boundary_next_s;
                end
            end
            S_T7: begin
                if (is_st_s && !mem_ready_s) begin
                    next_state_s = S_T7;
                end else begin
                    next_state_s = boundary_next_s;
                end
            end
            S_PAUSE: next_state_s = stop ? S_PAUSE : S_T0;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_RST;
        endcase
    end

    // Moore output decode from state and the opcode class.
    always_comb begin
        pc_out  = 1'b0;
        mar_in  = 1'b0;
        inc_pc  = 1'b0;
        pc_in   = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        mdr_in  = 1'b0;
        mdr_out = 1'b0;
        ir_in   = 1'b0;
        y_in    = 1'b0;
        z_in    = 1'b0;
        zlo_out = 1'b0;
        c_out   = 1'b0;
        con_in  = 1'b0;
        gra     = 1'b0;
        grb     = 1'b0;
        grc     = 1'b0;
        r_in    = 1'b0;
        r_out   = 1'b0;
        ba_out  = 1'b0;
        alu_op  = 5'b00000;
        run     = (state_r != S_HALT);
        case (state_r)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlo_out = 1'b1;
                pc_in   = 1'b1;
                read    = 1'b1;
                mdr_in  = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (is_ld_s || is_st_s || is_ldi_s) begin
                    grb    = 1'b1;
                    ba_out = 1'b1;
                    y_in   = 1'b1;
                end else if (is_r_s || is_imm_s) begin
                    grb   = 1'b1;
                    r_out = 1'b1;
                    y_in  = 1'b1;
                end else if (is_br_s) begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    con_in = 1'b1;
                end else begin
                    run = 1'b1;
                end
            end
            S_T4: begin
                if (is_r_s) begin
                    grc    = 1'b1;
                    r_out  = 1'b1;
                    z_in   = 1'b1;
                    alu_op = opcode_s;
                end else if (is_ld_s || is_st_s || is_ldi_s || is_imm_s) begin
                    c_out  = 1'b1;
                    z_in   = 1'b1;
                    alu_op = imm_alu_code(opcode_s);
                end else if (is_br_s) begin
                    pc_out = 1'b1;
                    y_in   = 1'b1;
                end else begin
                    run = 1'b1;
                end
            end
            S_T5: begin
                if (is_r_s || is_imm_s || is_ldi_s) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (is_ld_s || is_st_s) begin
                    zlo_out = 1'b1;
                    mar_in  = 1'b1;
                end else if (is_br_s) begin
                    c_out  = 1'b1;
                    z_in   = 1'b1;
                    alu_op = ALU_ADD;
                end else begin
                    run = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld_s) begin
                    read   = 1'b1;
                    mdr_in = 1'b1;
                end else if (is_st_s) begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    mdr_in = 1'b1;
                end else if (is_br_s) begin
                    zlo_out = con_ff;
                    pc_in   = con_ff;
                end else begin
                    run = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld_s) begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (is_st_s) begin
                    write = 1'b1;
                end else begin
                    run = 1'b1;
                end
            end
            default: begin
                run = (state_r != S_HALT);
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instruction sequences checked every cycle against a per-class strobe table.
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic        stop;
    logic [31:0] ir;
    logic        con_ff;
`ifdef SEQ_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic pc_out, mar_in, inc_pc, pc_in, read, write, mdr_in, mdr_out, ir_in, y_in;
    logic z_in, zlo_out, c_out, con_in, gra, grb, grc, r_in, r_out, ba_out, run;
    logic [4:0] alu_op;

    control_sequencer dut (
        .clk(clk), .reset(reset), .stop(stop), .ir(ir), .con_ff(con_ff),
`ifdef SEQ_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
        .read(read), .write(write), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out),
        .c_out(c_out), .con_in(con_in), .gra(gra), .grb(grb), .grc(grc),
        .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .alu_op(alu_op), .run(run)
    );

    // Output vector bit map: strobes 25..6, alu_op 5..1, run 0.
    localparam logic [25:0] PC_OUT  = 26'd1 << 25;
    localparam logic [25:0] MAR_IN  = 26'd1 << 24;
    localparam logic [25:0] INC_PC  = 26'd1 << 23;
    localparam logic [25:0] PC_IN   = 26'd1 << 22;
    localparam logic [25:0] READ    = 26'd1 << 21;
    localparam logic [25:0] WRITE   = 26'd1 << 20;
    localparam logic [25:0] MDR_IN  = 26'd1 << 19;
    localparam logic [25:0] MDR_OUT = 26'd1 << 18;
    localparam logic [25:0] IR_IN   = 26'd1 << 17;
    localparam logic [25:0] Y_IN    = 26'd1 << 16;
    localparam logic [25:0] Z_IN    = 26'd1 << 15;
    localparam logic [25:0] ZLO_OUT = 26'd1 << 14;
    localparam logic [25:0] C_OUT   = 26'd1 << 13;
    localparam logic [25:0] CON_IN  = 26'd1 << 12;
    localparam logic [25:0] GRA     = 26'd1 << 11;
    localparam logic [25:0] GRB     = 26'd1 << 10;
    localparam logic [25:0] GRC     = 26'd1 << 9;
    localparam logic [25:0] R_IN    = 26'd1 << 8;
    localparam logic [25:0] R_OUT   = 26'd1 << 7;
    localparam logic [25:0] BA_OUT  = 26'd1 << 6;
    localparam logic [25:0] RUN     = 26'd1;

    logic [25:0] dut_vec;
    assign dut_vec = {pc_out, mar_in, inc_pc, pc_in, read, write, mdr_in, mdr_out, ir_in, y_in,
                      z_in, zlo_out, c_out, con_in, gra, grb, grc, r_in, r_out, ba_out, alu_op, run};

    logic [25:0] exp_vec;
    logic        exp_valid;
    logic        done;
    string       tag;
    int          checks;
    int          errors;
    event        chk_ev;

    function automatic logic [25:0] alu(input logic [4:0] v);
        alu = {20'd0, v, 1'b0};
    endfunction

    // Cycles from T0 through the last execute state; halt counts only the fetch.
    function automatic int instr_len(input logic [4:0] op);
        if (op == 5'd0 || op == 5'd2)        instr_len = 8;
        else if (op >= 5'd1 && op <= 5'd14)  instr_len = 6;
        else if (op == 5'd18)                instr_len = 7;
        else if (op == 5'd27)                instr_len = 3;
        else                                 instr_len = 4;
    endfunction

    // Expected outputs in step k (0 = T0) of an instruction with opcode op.
    function automatic logic [25:0] exp_at(input logic [4:0] op, input logic con, input int k);
        logic [25:0] v;
        logic        is_ld;
        v = RUN;
        is_ld = (op == 5'd0);
        if (k == 0)      v |= PC_OUT | MAR_IN | INC_PC | Z_IN;
        else if (k == 1) v |= ZLO_OUT | PC_IN | READ | MDR_IN;
        else if (k == 2) v |= MDR_OUT | IR_IN;
        else if (op == 5'd0 || op == 5'd2) begin
            if (k == 3)      v |= GRB | BA_OUT | Y_IN;
            else if (k == 4) v |= C_OUT | Z_IN | alu(5'd3);
            else if (k == 5) v |= ZLO_OUT | MAR_IN;
            else if (k == 6) v |= is_ld ? (READ | MDR_IN) : (GRA | R_OUT | MDR_IN);
            else             v |= is_ld ? (MDR_OUT | GRA | R_IN) : WRITE;
        end else if (op >= 5'd1 && op <= 5'd14) begin
            if (k == 3) v |= GRB | Y_IN | ((op == 5'd1) ? BA_OUT : R_OUT);
            else if (k == 4) begin
                if (op >= 5'd3 && op <= 5'd11) v |= GRC | R_OUT | Z_IN | alu(op);
                else if (op == 5'd13)          v |= C_OUT | Z_IN | alu(5'd5);
                else if (op == 5'd14)          v |= C_OUT | Z_IN | alu(5'd6);
                else                           v |= C_OUT | Z_IN | alu(5'd3);
            end else v |= ZLO_OUT | GRA | R_IN;
        end else if (op == 5'd18) begin
            if (k == 3)      v |= GRA | R_OUT | CON_IN;
            else if (k == 4) v |= PC_OUT | Y_IN;
            else if (k == 5) v |= C_OUT | Z_IN | alu(5'd3);
            else if (con)    v |= ZLO_OUT | PC_IN;
        end
        exp_at = v;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single compare process: every falling edge, plus on-demand mid-cycle checks.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_valid) begin
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", tag, dut_vec, exp_vec);
                end
            end
        end
    end

    // Watchdog: the directed sequence must finish within a bounded wait.
    initial begin
        done = 1'b0;
        #100000;
        if (!done) begin
            errors++;
            $display("FAIL watchdog: wait expired before sequence completed");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else begin
            checks++;
        end
    end

    task automatic cyc(input logic [25:0] e);
        exp_vec   = e;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [4:0] op, input logic con, input logic stop_at_end,
                             input string name);
        int n;
        n      = instr_len(op);
        ir     = {op, 27'h2A51C3};
        con_ff = con;
        for (int k = 0; k < n; k++) begin
            stop = (k >= 3) ? stop_at_end : 1'b0;
            tag  = $sformatf("%s_T%0d", name, k);
            cyc(exp_at(op, con, k));
        end
    endtask

    initial begin
        exp_valid = 1'b0;
        exp_vec   = 26'd0;
        tag       = "idle";
        reset     = 1'b1;
        stop      = 1'b0;
        con_ff    = 1'b0;
        ir        = 32'd0;
`ifdef SEQ_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 26'h0000001) begin
            errors++;
            $display("FAIL reset_state_direct: got %h expected %h", dut_vec, 26'h0000001);
        end
        tag = "reset_state";
        cyc(26'h0000001);
        reset = 1'b0;
        tag = "reset_release";
        cyc(26'h0000001);

        run_instr(5'b00011, 1'b0, 1'b0, "add");

        // add again, aborted by reset in the middle of T4
        ir = {5'b00011, 27'h0123456};
        for (int k = 0; k < 4; k++) begin
            tag = $sformatf("add_abort_T%0d", k);
            cyc(exp_at(5'b00011, 1'b0, k));
        end
        tag = "add_T4_lit";
        exp_vec = 26'h0008287;
        -> chk_ev;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 26'h0000001) begin
            errors++;
            $display("FAIL async_reset_direct: got %h expected %h", dut_vec, 26'h0000001);
        end
        tag = "async_reset";
        exp_vec = 26'h0000001;
        -> chk_ev;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tag = "rst_after_abort";
        cyc(26'h0000001);
        ir = {5'b11010, 27'd0};
        tag = "T0_lit";
        cyc(26'h3808001);
        for (int k = 1; k < 4; k++) begin
            tag = $sformatf("nop_T%0d", k);
            cyc(exp_at(5'b11010, 1'b0, k));
        end

        run_instr(5'b01010, 1'b0, 1'b0, "ror");
        run_instr(5'b00111, 1'b0, 1'b0, "shr");
        run_instr(5'b00000, 1'b0, 1'b0, "ld");
        run_instr(5'b00010, 1'b0, 1'b0, "st");
        run_instr(5'b10010, 1'b0, 1'b0, "br_nt");
        run_instr(5'b10010, 1'b1, 1'b0, "br_t");
        run_instr(5'b00001, 1'b0, 1'b0, "ldi");
        run_instr(5'b01101, 1'b0, 1'b0, "andi");
        run_instr(5'b01110, 1'b0, 1'b0, "ori");
        run_instr(5'b10101, 1'b0, 1'b0, "undef");

        // addi with stop held from T3: pause three cycles, then resume
        run_instr(5'b01100, 1'b0, 1'b1, "addi_stop");
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stop = 1'b0;
            tag = $sformatf("pause_%0d", i);
            cyc(RUN);
        end
        run_instr(5'b11010, 1'b0, 1'b0, "nop_resume");

`ifdef SEQ_MEM_WAIT_EN
        ir = {5'b11010, 27'd0};
        tag = "mw_T0";
        cyc(exp_at(5'b11010, 1'b0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tag = $sformatf("mw_T1_hold%0d", i);
            cyc(exp_at(5'b11010, 1'b0, 1));
        end
        mem_ready = 1'b1;
        tag = "mw_T1_last";
        cyc(exp_at(5'b11010, 1'b0, 1));
        tag = "mw_T2";
        cyc(exp_at(5'b11010, 1'b0, 2));
        tag = "mw_T3";
        cyc(exp_at(5'b11010, 1'b0, 3));
`endif

        // halt, sit in HALT, recover only through reset
        run_instr(5'b11011, 1'b0, 1'b0, "halt");
        for (int i = 0; i < 4; i++) begin
            tag = $sformatf("halted_%0d", i);
            cyc(26'h0000000);
        end
        reset = 1'b1;
        tag = "halt_reset";
        cyc(26'h0000001);
        reset = 1'b0;
        tag = "halt_release";
        cyc(26'h0000001);
        run_instr(5'b00100, 1'b0, 1'b0, "sub_after_halt");

        exp_valid = 1'b0;
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
